branch_controller: RTL
======================

// Module: branch_controller
// PURPOSE
//  Branch hazard controller for the pipelined processor. Holds a 2-bit saturating
//  branch history table (BHT) read at fetch to predict direction, and compares the
//  prediction against the EX-stage result from branch resolution. On a mispredict it
//  sequences pipeline recovery: PC redirect, then a multi-cycle flush of IF/ID and ID/EX.
//  It also keeps performance counters for branches and mispredicts.
// PARAMETERS
//  IDX_W         4   BHT index width; BHT has 2**IDX_W entries
//  FLUSH_CYCLES  2   cycles flush_if_id/flush_id_ex stay high per mispredict (>=1)
//  CNT_W         16  width of perf counters
// PORTS
//  clock            in   1      single clock, rising edge
//  reset            in   1      asynchronous, active-high
//  fetch_pc         in   32     PC of instruction in IF
//  fetch_is_branch  in   1      predecode: IF instruction is a conditional branch
//  predict_taken    out  1      prediction for IF branch (combinational)
//  ex_valid         in   1      EX stage holds a valid, non-squashed instruction
//  ex_is_branch     in   1      EX instruction is a conditional branch
//  ex_branch_taken  in   1      resolved direction from branch resolution logic
//  ex_predicted     in   1      prediction carried down the pipe with this branch
//  ex_pc            in   32     PC of EX branch
//  ex_target        in   32     computed branch target of EX branch
//  redirect_valid   out  1      registered; fetch must load redirect_pc this cycle
//  redirect_pc      out  32     registered recovery PC
//  flush_if_id      out  1      registered; squash IF/ID register
//  flush_id_ex      out  1      registered; squash ID/EX register
//  branch_count     out  CNT_W  resolved branches since reset
//  mispredict_count out  CNT_W  mispredicts since reset
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0, state IDLE, every BHT entry = 2'b01 (weak NT).
//  BHT index = fetch_pc[IDX_W+1:2] for read, ex_pc[IDX_W+1:2] for update.
//  predict_taken = fetch_is_branch & BHT[idx][1]; 0 whenever fetch_is_branch=0.
//  resolve = ex_valid & ex_is_branch & (state==IDLE).
//  mispredict = resolve & (ex_branch_taken != ex_predicted).
//  On resolve at a clock edge: BHT[ex idx] +1 if taken (saturates at 11), -1 if not
//   (saturates at 00); branch_count +1. Same-cycle read/update of same index: read
//   returns pre-update value.
//  Counters saturate at all-ones; no wrap.
//  FSM, one-hot or encoded, states IDLE, REDIRECT, FLUSH:
//   IDLE: outputs redirect_valid/flush_* = 0. If mispredict -> REDIRECT next cycle;
//    redirect_pc <= ex_branch_taken ? ex_target : ex_pc+4 (32-bit, wraps mod 2**32);
//    mispredict_count +1.
//   REDIRECT (1 cycle): redirect_valid=1, flush_if_id=1, flush_id_ex=1.
//    FLUSH_CYCLES==1 -> IDLE, else -> FLUSH with down-counter = FLUSH_CYCLES-2.
//   FLUSH: redirect_valid=0, both flushes=1; counter==0 -> IDLE, else decrement.
//  Latency: mispredict seen at edge N -> redirect_valid high in cycle N+1 only;
//   flushes high cycles N+1 .. N+FLUSH_CYCLES.
//  EX inputs are ignored outside IDLE (wrong-path instructions): no BHT update, no count.
//  Correct predictions never leave IDLE and never assert flush.
//  Reset mid-REDIRECT/FLUSH: outputs drop to 0 immediately, FSM to IDLE.
// TESTING
//  1 Reset asserted mid-cycle -> all outputs 0 at once; fetch_pc=0x40,is_branch=1 -> predict_taken=0.
//  2 IDLE, ex branch pc=0x40 predicted=0 taken=1 target=0x100 -> next cycle redirect_valid=1,
//    redirect_pc=0x100; flushes high 2 cycles; mispredict_count=1, branch_count=1.
//  3 Two resolved taken branches at pc=0x40 (correctly predicted flag) -> entry 11;
//    fetch_pc=0x80 (same idx for IDX_W=4) is_branch=1 -> predict_taken=1; no flush.
//  4 ex_pc=0xFFFFFFFC predicted=1 taken=0 -> redirect_pc=0x00000000.
//  5 Mispredicting ex branch presented during FLUSH -> ignored: counts unchanged, BHT unchanged,
//    FSM returns to IDLE on schedule.
//  6 Reset asserted in FLUSH -> flushes 0 immediately; after release BHT entries read 01.

Source files
------------

// File: rtl/branch_controller.sv
// Branch hazard controller: 2-bit saturating BHT for fetch-time direction
// prediction, mispredict detection against the EX-stage resolved direction,
// recovery sequencing (PC redirect then multi-cycle IF/ID + ID/EX flush),
// and saturating performance counters.
module branch_controller #(
  parameter int IDX_W        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      fetch_pc,
  input  logic             fetch_is_branch,
  output logic             predict_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_branch_taken,
  input  logic             ex_predicted,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int BHT_SIZE = 1 << IDX_W;
  // Down-counter only needs to hold FLUSH_CYCLES-2; keep at least one bit.
  localparam int FC_W     = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t           state;
  logic [FC_W-1:0]  flush_cnt;
  logic [1:0]       bht [BHT_SIZE];

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             resolve;
  logic             mispredict;

  // Word-aligned PCs: drop the byte offset, take the next IDX_W bits.
  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign ex_idx    = ex_pc[IDX_W+1:2];

  // Fetch PC bits outside the index field do not participate in prediction.
  logic unused_fetch_pc_bits;
  assign unused_fetch_pc_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0]};

  // Array read sees the pre-update value when read and update hit the same entry.
  assign predict_taken = fetch_is_branch & bht[fetch_idx][1];

  // Anything arriving in EX while recovering is wrong-path and must be ignored.
  assign resolve    = ex_valid & ex_is_branch & (state == IDLE);
  assign mispredict = resolve & (ex_branch_taken != ex_predicted);

  // BHT: 2-bit saturating counters trained by resolved branches.
  // NOTE: the table is reset entry-by-entry because every counter must start
  // at weak-not-taken; this makes it flops, not an inferable RAM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_SIZE; i++) begin
        bht[IDX_W'(i)] <= 2'b01;
      end
    end else if (resolve) begin
      if (ex_branch_taken) begin
        if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'd1;
      end else begin
        if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'd1;
      end
    end
  end

  // Performance counters: saturate at all-ones rather than wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (resolve && (branch_count != '1)) begin
        branch_count <= branch_count + CNT_W'(1);
      end
      if (mispredict && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

  // Recovery FSM with registered redirect/flush outputs.
  // NOTE: outputs are assigned on the transition into each state so they are
  // flops aligned with the state register, never decoded combinationally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_if_id    <= 1'b0;
      flush_id_ex    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mispredict) begin
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            flush_if_id    <= 1'b1;
            flush_id_ex    <= 1'b1;
            // Taken-but-predicted-NT goes to target; the reverse falls through.
            redirect_pc    <= ex_branch_taken ? ex_target : (ex_pc + 32'd4);
          end
        end
        REDIRECT: begin
          redirect_valid <= 1'b0;
          if (FLUSH_CYCLES == 1) begin
            state       <= IDLE;
            flush_if_id <= 1'b0;
            flush_id_ex <= 1'b0;
          end else begin
            state     <= FLUSH;
            flush_cnt <= FC_W'(FLUSH_CYCLES - 2);
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state       <= IDLE;
            flush_if_id <= 1'b0;
            flush_id_ex <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - FC_W'(1);
          end
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
          flush_if_id    <= 1'b0;
          flush_id_ex    <= 1'b0;
        end
      endcase
    end
  end

endmodule
